// File: rtl/key_pulse_driver.sv
// Key pulse driver: turns single-cycle event flags into timed ON/GAP
// pulses on a board output, queueing flags that arrive while busy.
module key_pulse_driver #(
  parameter int                   CNT_WIDTH  = 21,
  parameter logic [CNT_WIDTH-1:0] ON_MAX     = 21'd1_999_999,
  parameter logic [CNT_WIDTH-1:0] GAP_MAX    = 21'd1_999_999,
  parameter int                   PEND_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ev_flag,
  input  logic                  clr,
  output logic                  out_level,
  output logic                  busy,
  output logic [PEND_WIDTH-1:0] pend_cnt,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  state_t                state_q;
  state_t                state_d;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic [PEND_WIDTH-1:0] pend_d;
  logic                  ovf_d;

  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic [PEND_WIDTH-1:0] pend_inc;
  logic [PEND_WIDTH-1:0] pend_dec;
  logic                  pend_full;

  assign cnt_inc   = cnt_q + CNT_WIDTH'(1);
  assign pend_inc  = pend_cnt + PEND_WIDTH'(1);
  assign pend_dec  = pend_cnt - PEND_WIDTH'(1);
  assign pend_full = (pend_cnt == PEND_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_cnt;
    ovf_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ev_flag) begin
          state_d = ON;
          cnt_d   = '0;
        end
      end
      ON: begin
        if (cnt_q == ON_MAX) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
        if (ev_flag) begin
          if (pend_full) ovf_d = 1'b1;
          else           pend_d = pend_inc;
        end
      end
      GAP: begin
        if (cnt_q == GAP_MAX) begin
          cnt_d = '0;
          // A flag on the terminal edge cancels the dequeue
          if (pend_cnt != '0) begin
            state_d = ON;
            pend_d  = ev_flag ? pend_cnt : pend_dec;
          end else if (ev_flag) begin
            state_d = ON;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_inc;
          if (ev_flag) begin
            if (pend_full) ovf_d = 1'b1;
            else           pend_d = pend_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = '0;
      end
    endcase
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_cnt  <= '0;
      out_level <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_cnt  <= pend_d;
      out_level <= (state_d == ON);
      busy      <= (state_d != IDLE);
      overflow  <= ovf_d;
    end
  end

endmodule
